any1_rob_tracker: RTL and testbench
===================================

ANY1_ROB_TRACKER -- requirements
Module: any1_rob_tracker

Interface
REQ-001 SHALL have parameter ENTRIES, default 8, reorder-buffer depth, power of two, 4..64.
REQ-002 SHALL have parameter WB_PORTS, default 4, functional-unit writeback channels (exec, mul, div, mem).
REQ-003 SHALL have parameter CMT_WIDTH, default 2, maximum in-order commits per cycle, 1..4.
REQ-004 SHALL have localparam RIDW = log2(ENTRIES).
REQ-005 SHALL have ports:
  clk_i  in  1  sole clock; all state updates on rising edge.
  rst_i  in  1  synchronous, active-low reset.
  alloc_i  in  1  allocate one entry at tail.
  alloc_rt_i  in  8  destination register of allocated instruction.
  alloc_rfwr_i  in  1  register-file write required.
  alloc_rdy_o  out  1  buffer not full; allocation accepted.
  alloc_rid_o  out  RIDW  rid assigned to the allocation (current tail).
  wb_v_i  in  WB_PORTS  per-port writeback valid.
  wb_rid_i  in  WB_PORTS*RIDW  per-port target rid.
  wb_res_i  in  WB_PORTS*64  per-port result.
  wb_cause_i  in  WB_PORTS*16  per-port fault cause, 0 = none.
  cmt_rdy_i  in  1  commit consumer ready.
  cmt_v_o  out  CMT_WIDTH  commit slot valid.
  cmt_rid_o / cmt_rt_o / cmt_rfwr_o / cmt_res_o / cmt_cause_o  out  CMT_WIDTH x (RIDW/8/1/64/16)  per-slot payload.
  flush_i  in  1  discard all entries younger than flush_rid_i.
  flush_rid_i  in  RIDW  youngest surviving entry.
  count_o  out  RIDW+1  occupied entries.

Function
REQ-006 SHALL hold per entry: v, done, rt, rfwr, res, cause; head, tail pointers (RIDW bits, wrap modulo ENTRIES) and count.
REQ-007 alloc_rdy_o SHALL be (count_o != ENTRIES), from registered state only; no same-cycle pass-through of commits.
REQ-008 Allocation accepted when alloc_i & alloc_rdy_o & !flush_i: entry[tail] gets v=1, done=0, rt, rfwr, cause=0; tail increments.
REQ-009 Writeback on port p SHALL set done=1, res, cause of entry wb_rid_i[p] only if that entry has v=1 and done=0 at the edge; otherwise ignored.
REQ-010 Same-cycle writebacks to one rid: lowest-numbered port wins; others dropped.
REQ-011 Writeback to the entry being allocated in the same cycle SHALL be ignored.
REQ-012 Slot k (0..CMT_WIDTH-1) SHALL be valid when entry head+k has v&done, all slots <k valid, k < count, and no slot <k carries cause != 0.
REQ-013 Slot with cause != 0 SHALL commit only as slot 0; slot k>0 with nonzero cause is not valid that cycle.
REQ-014 cmt_* outputs SHALL be combinational from registered state; writeback at edge N is first visible on cmt_v_o after edge N.
REQ-015 When cmt_rdy_i=1, all valid slots SHALL retire at the edge: v cleared, head advances by number of valid slots; cmt_rdy_i=0 holds state.
REQ-016 Flush SHALL clear v of every entry strictly younger than flush_rid_i and set tail = flush_rid_i+1 (mod ENTRIES); allocation ignored that cycle.
REQ-017 In a flush cycle, commit slots whose rid is younger than flush_rid_i SHALL be forced invalid; older/equal slots commit normally.
REQ-018 flush_rid_i naming an entry with v=0 SHALL be ignored (no state change).
REQ-019 count_o SHALL equal (tail-head) mod 2*ENTRIES using an extra wrap bit, updated for simultaneous alloc, commit and flush in one edge.
REQ-020 Full with simultaneous commit: allocation still refused that cycle (REQ-007).

Reset
REQ-021 While rst_i=0 at an edge: all v/done cleared, head=tail=0, count_o=0; outputs then: alloc_rdy_o=1, alloc_rid_o=0, cmt_v_o=0, payload outputs 0.
REQ-022 Reset SHALL override alloc, writeback, commit and flush in the same cycle.

Verification
REQ-023 Reset, alloc 8 (ENTRIES=8) -> rids 0..7, count_o=8, alloc_rdy_o=0; 9th alloc ignored, tail stays 0.
REQ-024 Alloc rids 0,1,2; wb rid2 then rid0 -> slot0 rid0 only; wb rid1 -> next cycle slots 0,1 = rid1,rid2, head=3.
REQ-025 wb rid0 cause=0x0027, rid1 done -> slot0 rid0 cause 0x0027, slot1 invalid; next cycle rid1 commits.
REQ-026 Ports 0 and 3 both write rid4 same cycle, res 0xAA / 0xBB -> committed res 0xAA.
REQ-027 Entries 0..5 valid, flush_rid_i=2 with alloc_i=1 -> tail=3, count_o=3, no allocation, rids 3..5 never commit.
REQ-028 Head=6, alloc 4 wraps to rids 6,7,0,1; all done, cmt_rdy_i toggling 0/1 -> commits in order 6,7,0,1, count_o returns 0.

Source files
------------

// File: rtl/any1_rob_tracker.sv
// rtl/any1_rob_tracker.sv - reorder-buffer occupancy/writeback/commit tracker
// Tracks in-flight instructions from allocation through writeback to in-order retirement.
module any1_rob_tracker #(
   parameter int ENTRIES   = 8,
   parameter int WB_PORTS  = 4,
   parameter int CMT_WIDTH = 2,
   localparam int RIDW     = $clog2(ENTRIES)
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       alloc_i,
   input  logic [7:0]                 alloc_rt_i,
   input  logic                       alloc_rfwr_i,
   output logic                       alloc_rdy_o,
   output logic [RIDW-1:0]            alloc_rid_o,
   input  logic [WB_PORTS-1:0]        wb_v_i,
   input  logic [WB_PORTS*RIDW-1:0]   wb_rid_i,
   input  logic [WB_PORTS*64-1:0]     wb_res_i,
   input  logic [WB_PORTS*16-1:0]     wb_cause_i,
   input  logic                       cmt_rdy_i,
   output logic [CMT_WIDTH-1:0]       cmt_v_o,
   output logic [CMT_WIDTH*RIDW-1:0]  cmt_rid_o,
   output logic [CMT_WIDTH*8-1:0]     cmt_rt_o,
   output logic [CMT_WIDTH-1:0]       cmt_rfwr_o,
   output logic [CMT_WIDTH*64-1:0]    cmt_res_o,
   output logic [CMT_WIDTH*16-1:0]    cmt_cause_o,
   input  logic                       flush_i,
   input  logic [RIDW-1:0]            flush_rid_i,
   output logic [RIDW:0]              count_o
);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [RIDW:0]        head_q, tail_q, tail_d, nret;
   logic [RIDW-1:0]      head_idx, tail_idx, age_f;
   logic [ENTRIES-1:0]   v_q, done_q, rfwr_q, wb_ok, younger;
   logic [7:0]           rt_q     [ENTRIES];
   logic [63:0]          res_q    [ENTRIES];
   logic [15:0]          cause_q  [ENTRIES];
   logic [63:0]          wb_res   [ENTRIES];
   logic [15:0]          wb_cause [ENTRIES];
   logic [RIDW-1:0]      slot_idx [CMT_WIDTH];
   logic [CMT_WIDTH-1:0] slot_ok;
   logic                 alloc_fire, flush_eff, chain;

   assign head_idx    = head_q[RIDW-1:0];
   assign tail_idx    = tail_q[RIDW-1:0];
   assign count_o     = tail_q - head_q;
   assign alloc_rdy_o = (count_o != (RIDW+1)'(ENTRIES));
   assign alloc_rid_o = tail_idx;
   assign alloc_fire  = alloc_i & alloc_rdy_o & ~flush_i;
   assign flush_eff   = flush_i & v_q[flush_rid_i];
   assign age_f       = flush_rid_i - head_idx;

   always_comb begin
      for (int e = 0; e < ENTRIES; e++) begin
         wb_ok[e]    = 1'b0;
         wb_res[e]   = '0;
         wb_cause[e] = '0;
         // Descending scan so the lowest-numbered matching port is the one kept.
         for (int p = WB_PORTS-1; p >= 0; p--) begin
            if (wb_v_i[p] && (wb_rid_i[p*RIDW +: RIDW] == RIDW'(e))) begin
               wb_ok[e]    = 1'b1;
               wb_res[e]   = wb_res_i[p*64 +: 64];
               wb_cause[e] = wb_cause_i[p*16 +: 16];
            end
         end
         if (!v_q[e] || done_q[e] || (alloc_fire && (tail_idx == RIDW'(e))))
            wb_ok[e] = 1'b0;
         younger[e] = flush_eff && ((RIDW'(e) - head_idx) > age_f);
      end
   end

   always_comb begin
      chain       = 1'b1;
      nret        = '0;
      slot_ok     = '0;
      cmt_v_o     = '0;
      cmt_rid_o   = '0;
      cmt_rt_o    = '0;
      cmt_rfwr_o  = '0;
      cmt_res_o   = '0;
      cmt_cause_o = '0;
      for (int k = 0; k < CMT_WIDTH; k++) begin
         slot_idx[k] = head_idx + RIDW'(k);
         slot_ok[k]  = chain && v_q[slot_idx[k]] && done_q[slot_idx[k]]
                       && ((RIDW+1)'(k) < count_o)
                       && ((k == 0) || (cause_q[slot_idx[k]] == 16'h0))
                       && !(flush_eff && (RIDW'(k) > age_f));
         chain = slot_ok[k] && (cause_q[slot_idx[k]] == 16'h0);
         if (slot_ok[k]) begin
            cmt_v_o[k]                 = 1'b1;
            cmt_rid_o[k*RIDW +: RIDW]  = slot_idx[k];
            cmt_rt_o[k*8 +: 8]         = rt_q[slot_idx[k]];
            cmt_rfwr_o[k]              = rfwr_q[slot_idx[k]];
            cmt_res_o[k*64 +: 64]      = res_q[slot_idx[k]];
            cmt_cause_o[k*16 +: 16]    = cause_q[slot_idx[k]];
            if (cmt_rdy_i)
               nret = nret + (RIDW+1)'(1);
         end
      end
   end

   always_comb begin
      tail_d = tail_q;
      if (flush_eff)
         tail_d = head_q + {1'b0, age_f} + (RIDW+1)'(1);
      else if (alloc_fire)
         tail_d = tail_q + (RIDW+1)'(1);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         v_q    <= '0;
         done_q <= '0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         for (int e = 0; e < ENTRIES; e++) begin
            if (wb_ok[e]) begin
               done_q[e]  <= 1'b1;
               res_q[e]   <= wb_res[e];
               cause_q[e] <= wb_cause[e];
            end
            if (younger[e])
               v_q[e] <= 1'b0;
         end
         for (int k = 0; k < CMT_WIDTH; k++) begin
            if (slot_ok[k] && cmt_rdy_i)
               v_q[slot_idx[k]] <= 1'b0;
         end
         if (alloc_fire) begin
            v_q[tail_idx]     <= 1'b1;
            done_q[tail_idx]  <= 1'b0;
            rt_q[tail_idx]    <= alloc_rt_i;
            rfwr_q[tail_idx]  <= alloc_rfwr_i;
            cause_q[tail_idx] <= 16'h0;
         end
         head_q <= head_q + nret;
         tail_q <= tail_d;
      end
   end

endmodule

// File: tb/tb_any1_rob_tracker.sv
// tb/tb_any1_rob_tracker.sv - directed self-checking bench for any1_rob_tracker
module tb_any1_rob_tracker;
   localparam int E = 8;
   localparam int W = 4;
   localparam int C = 2;
   localparam int R = 3;

   logic            clk;
   logic            rst_i;
   logic            alloc_i;
   logic [7:0]      alloc_rt_i;
   logic            alloc_rfwr_i;
   logic            alloc_rdy_o;
   logic [R-1:0]    alloc_rid_o;
   logic [W-1:0]    wb_v_i;
   logic [W*R-1:0]  wb_rid_i;
   logic [W*64-1:0] wb_res_i;
   logic [W*16-1:0] wb_cause_i;
   logic            cmt_rdy_i;
   logic [C-1:0]    cmt_v_o;
   logic [C*R-1:0]  cmt_rid_o;
   logic [C*8-1:0]  cmt_rt_o;
   logic [C-1:0]    cmt_rfwr_o;
   logic [C*64-1:0] cmt_res_o;
   logic [C*16-1:0] cmt_cause_o;
   logic            flush_i;
   logic [R-1:0]    flush_rid_i;
   logic [R:0]      count_o;

   int pass_cnt = 0;
   int total_cnt = 0;

   any1_rob_tracker #(.ENTRIES(E), .WB_PORTS(W), .CMT_WIDTH(C)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .alloc_i(alloc_i), .alloc_rt_i(alloc_rt_i), .alloc_rfwr_i(alloc_rfwr_i),
      .alloc_rdy_o(alloc_rdy_o), .alloc_rid_o(alloc_rid_o),
      .wb_v_i(wb_v_i), .wb_rid_i(wb_rid_i), .wb_res_i(wb_res_i), .wb_cause_i(wb_cause_i),
      .cmt_rdy_i(cmt_rdy_i), .cmt_v_o(cmt_v_o), .cmt_rid_o(cmt_rid_o), .cmt_rt_o(cmt_rt_o),
      .cmt_rfwr_o(cmt_rfwr_o), .cmt_res_o(cmt_res_o), .cmt_cause_o(cmt_cause_o),
      .flush_i(flush_i), .flush_rid_i(flush_rid_i), .count_o(count_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      alloc_i      = 1'b0;
      alloc_rt_i   = '0;
      alloc_rfwr_i = 1'b0;
      wb_v_i       = '0;
      wb_rid_i     = '0;
      wb_res_i     = '0;
      wb_cause_i   = '0;
      flush_i      = 1'b0;
      flush_rid_i  = '0;
   endtask

   task automatic wb_set(input int p, input logic [R-1:0] rid, input logic [63:0] res,
                         input logic [15:0] cause);
      wb_v_i[p]          = 1'b1;
      wb_rid_i[p*R +: R] = rid;
      wb_res_i[p*64 +: 64] = res;
      wb_cause_i[p*16 +: 16] = cause;
   endtask

   task automatic do_reset;
      idle();
      cmt_rdy_i = 1'b0;
      rst_i = 1'b0;
      tick();
      rst_i = 1'b1;
   endtask

   task automatic alloc_n(input int n, input int rt);
      for (int i = 0; i < n; i++) begin
         alloc_i = 1'b1;
         alloc_rt_i = 8'(rt + i);
         alloc_rfwr_i = 1'b1;
         tick();
      end
      alloc_i = 1'b0;
   endtask

   task automatic test_reset;
      idle();
      rst_i = 1'b0;
      alloc_i = 1'b1;
      wb_set(0, 3'd0, 64'h1, 16'h1);
      flush_i = 1'b1;
      cmt_rdy_i = 1'b1;
      tick();
      idle();
      #1;
      total_cnt++;
      if (count_o !== 4'd0) $display("FAIL reset_count got %0d want 0", count_o); else pass_cnt++;
      total_cnt++;
      if (alloc_rdy_o !== 1'b1) $display("FAIL reset_rdy got %b want 1", alloc_rdy_o); else pass_cnt++;
      total_cnt++;
      if (alloc_rid_o !== 3'd0) $display("FAIL reset_rid got %0d want 0", alloc_rid_o); else pass_cnt++;
      total_cnt++;
      if (cmt_v_o !== 2'b00) $display("FAIL reset_cmt_v got %b want 00", cmt_v_o); else pass_cnt++;
      total_cnt++;
      if (cmt_res_o !== '0 || cmt_cause_o !== '0)
         $display("FAIL reset_payload got res %h cause %h want 0", cmt_res_o, cmt_cause_o);
      else pass_cnt++;
      rst_i = 1'b1;
   endtask

   task automatic test_fill;
      do_reset();
      for (int i = 0; i < E; i++) begin
         alloc_i = 1'b1;
         #1;
         total_cnt++;
         if (alloc_rid_o !== 3'(i)) $display("FAIL fill_rid got %0d want %0d", alloc_rid_o, i);
         else pass_cnt++;
         tick();
      end
      alloc_i = 1'b0;
      #1;
      total_cnt++;
      if (count_o !== 4'd8) $display("FAIL fill_count got %0d want 8", count_o); else pass_cnt++;
      total_cnt++;
      if (alloc_rdy_o !== 1'b0) $display("FAIL fill_rdy got %b want 0", alloc_rdy_o); else pass_cnt++;
      alloc_i = 1'b1;
      tick();
      alloc_i = 1'b0;
      #1;
      total_cnt++;
      if (count_o !== 4'd8 || alloc_rid_o !== 3'd0)
         $display("FAIL fill_ninth got count %0d tail %0d want 8 0", count_o, alloc_rid_o);
      else pass_cnt++;
   endtask

   task automatic test_wb_order;
      do_reset();
      cmt_rdy_i = 1'b1;
      alloc_n(3, 10);
      wb_set(0, 3'd2, 64'h22, 16'h0);
      tick();
      idle();
      #1;
      total_cnt++;
      if (cmt_v_o !== 2'b00 || count_o !== 4'd3)
         $display("FAIL order_hold got v %b count %0d want 00 3", cmt_v_o, count_o);
      else pass_cnt++;
      wb_set(0, 3'd0, 64'h20, 16'h0);
      tick();
      idle();
      #1;
      total_cnt++;
      if (cmt_v_o !== 2'b01 || cmt_rid_o[R-1:0] !== 3'd0 || cmt_res_o[63:0] !== 64'h20)
         $display("FAIL order_rid0 got v %b rid %0d res %h want 01 0 20",
                  cmt_v_o, cmt_rid_o[R-1:0], cmt_res_o[63:0]);
      else pass_cnt++;
      total_cnt++;
      if (cmt_rt_o[7:0] !== 8'd10 || cmt_rfwr_o[0] !== 1'b1)
         $display("FAIL order_rt got rt %0d rfwr %b want 10 1", cmt_rt_o[7:0], cmt_rfwr_o[0]);
      else pass_cnt++;
      wb_set(0, 3'd1, 64'h21, 16'h0);
      tick();
      idle();
      #1;
      total_cnt++;
      if (cmt_v_o !== 2'b11 || cmt_rid_o[R-1:0] !== 3'd1 || cmt_rid_o[2*R-1:R] !== 3'd2)
         $display("FAIL order_pair got v %b rids %0d %0d want 11 1 2",
                  cmt_v_o, cmt_rid_o[R-1:0], cmt_rid_o[2*R-1:R]);
      else pass_cnt++;
      total_cnt++;
      if (cmt_res_o[127:64] !== 64'h22 || cmt_rt_o[15:8] !== 8'd12)
         $display("FAIL order_slot1 got res %h rt %0d want 22 12", cmt_res_o[127:64], cmt_rt_o[15:8]);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (count_o !== 4'd0 || alloc_rid_o !== 3'd3 || cmt_v_o !== 2'b00)
         $display("FAIL order_drain got count %0d tail %0d v %b want 0 3 00",
                  count_o, alloc_rid_o, cmt_v_o);
      else pass_cnt++;
   endtask

   task automatic test_cause;
      do_reset();
      alloc_n(2, 0);
      cmt_rdy_i = 1'b1;
      wb_set(0, 3'd0, 64'h1, 16'h0027);
      wb_set(1, 3'd1, 64'h2, 16'h0);
      tick();
      idle();
      #1;
      total_cnt++;
      if (cmt_v_o !== 2'b01 || cmt_cause_o[15:0] !== 16'h0027 || cmt_rid_o[R-1:0] !== 3'd0)
         $display("FAIL cause_slot0 got v %b cause %h rid %0d want 01 0027 0",
                  cmt_v_o, cmt_cause_o[15:0], cmt_rid_o[R-1:0]);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (cmt_v_o !== 2'b01 || cmt_rid_o[R-1:0] !== 3'd1 || cmt_cause_o[15:0] !== 16'h0)
         $display("FAIL cause_next got v %b rid %0d cause %h want 01 1 0",
                  cmt_v_o, cmt_rid_o[R-1:0], cmt_cause_o[15:0]);
      else pass_cnt++;
      tick();
      cmt_rdy_i = 1'b0;
      alloc_n(2, 0);
      wb_set(0, 3'd2, 64'h3, 16'h0);
      wb_set(1, 3'd3, 64'h4, 16'h0005);
      tick();
      idle();
      #1;
      total_cnt++;
      if (cmt_v_o !== 2'b01) $display("FAIL cause_slot1_block got %b want 01", cmt_v_o); else pass_cnt++;
      cmt_rdy_i = 1'b1;
      tick();
      total_cnt++;
      if (cmt_v_o !== 2'b01 || cmt_rid_o[R-1:0] !== 3'd3 || cmt_cause_o[15:0] !== 16'h0005)
         $display("FAIL cause_late got v %b rid %0d cause %h want 01 3 0005",
                  cmt_v_o, cmt_rid_o[R-1:0], cmt_cause_o[15:0]);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (count_o !== 4'd0) $display("FAIL cause_drain got %0d want 0", count_o); else pass_cnt++;
   endtask

   task automatic test_port_priority;
      do_reset();
      alloc_n(5, 0);
      for (int p = 0; p < W; p++) wb_set(p, 3'(p), 64'(p), 16'h0);
      tick();
      idle();
      wb_set(0, 3'd4, 64'hAA, 16'h0);
      wb_set(3, 3'd4, 64'hBB, 16'h0);
      wb_set(1, 3'd0, 64'h99, 16'h0);
      tick();
      idle();
      cmt_rdy_i = 1'b1;
      #1;
      total_cnt++;
      if (cmt_v_o !== 2'b11 || cmt_res_o[63:0] !== 64'h0 || cmt_res_o[127:64] !== 64'h1)
         $display("FAIL prio_done_ignored got v %b res %h %h want 11 0 1",
                  cmt_v_o, cmt_res_o[63:0], cmt_res_o[127:64]);
      else pass_cnt++;
      tick();
      tick();
      total_cnt++;
      if (cmt_v_o !== 2'b01 || cmt_rid_o[R-1:0] !== 3'd4 || cmt_res_o[63:0] !== 64'hAA)
         $display("FAIL prio_low_port got v %b rid %0d res %h want 01 4 aa",
                  cmt_v_o, cmt_rid_o[R-1:0], cmt_res_o[63:0]);
      else pass_cnt++;
      tick();
      alloc_i = 1'b1;
      wb_set(0, 3'd5, 64'h77, 16'h0);
      tick();
      idle();
      #1;
      total_cnt++;
      if (count_o !== 4'd1 || cmt_v_o !== 2'b00)
         $display("FAIL prio_alloc_wb got count %0d v %b want 1 00", count_o, cmt_v_o);
      else pass_cnt++;
      wb_set(0, 3'd5, 64'h55, 16'h0);
      tick();
      idle();
      #1;
      total_cnt++;
      if (cmt_v_o !== 2'b01 || cmt_rid_o[R-1:0] !== 3'd5 || cmt_res_o[63:0] !== 64'h55)
         $display("FAIL prio_late_wb got v %b rid %0d res %h want 01 5 55",
                  cmt_v_o, cmt_rid_o[R-1:0], cmt_res_o[63:0]);
      else pass_cnt++;
   endtask

   task automatic test_flush;
      do_reset();
      alloc_n(6, 0);
      for (int p = 0; p < W; p++) wb_set(p, 3'(p), 64'(p), 16'h0);
      tick();
      idle();
      wb_set(0, 3'd4, 64'h4, 16'h0);
      wb_set(1, 3'd5, 64'h5, 16'h0);
      tick();
      idle();
      flush_i = 1'b1;
      flush_rid_i = 3'd2;
      alloc_i = 1'b1;
      tick();
      idle();
      #1;
      total_cnt++;
      if (alloc_rid_o !== 3'd3 || count_o !== 4'd3)
         $display("FAIL flush_tail got tail %0d count %0d want 3 3", alloc_rid_o, count_o);
      else pass_cnt++;
      cmt_rdy_i = 1'b1;
      #1;
      total_cnt++;
      if (cmt_v_o !== 2'b11 || cmt_rid_o[R-1:0] !== 3'd0 || cmt_rid_o[2*R-1:R] !== 3'd1)
         $display("FAIL flush_keep got v %b rids %0d %0d want 11 0 1",
                  cmt_v_o, cmt_rid_o[R-1:0], cmt_rid_o[2*R-1:R]);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (cmt_v_o !== 2'b01 || cmt_rid_o[R-1:0] !== 3'd2)
         $display("FAIL flush_last got v %b rid %0d want 01 2", cmt_v_o, cmt_rid_o[R-1:0]);
      else pass_cnt++;
      tick();
      tick();
      total_cnt++;
      if (count_o !== 4'd0 || cmt_v_o !== 2'b00)
         $display("FAIL flush_gone got count %0d v %b want 0 00", count_o, cmt_v_o);
      else pass_cnt++;
      alloc_n(2, 0);
      wb_set(0, 3'd3, 64'h3, 16'h0);
      wb_set(1, 3'd4, 64'h4, 16'h0);
      tick();
      idle();
      flush_i = 1'b1;
      flush_rid_i = 3'd3;
      #1;
      total_cnt++;
      if (cmt_v_o !== 2'b01) $display("FAIL flush_mask got %b want 01", cmt_v_o); else pass_cnt++;
      tick();
      idle();
      #1;
      total_cnt++;
      if (count_o !== 4'd0 || alloc_rid_o !== 3'd4)
         $display("FAIL flush_commit got count %0d tail %0d want 0 4", count_o, alloc_rid_o);
      else pass_cnt++;
      flush_i = 1'b1;
      flush_rid_i = 3'd6;
      alloc_i = 1'b1;
      tick();
      idle();
      #1;
      total_cnt++;
      if (count_o !== 4'd0 || alloc_rid_o !== 3'd4)
         $display("FAIL flush_invalid got count %0d tail %0d want 0 4", count_o, alloc_rid_o);
      else pass_cnt++;
   endtask

   task automatic test_wrap;
      int got[$];
      int exp_r[4];
      exp_r = '{6, 7, 0, 1};
      do_reset();
      cmt_rdy_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         alloc_i = 1'b1;
         tick();
         alloc_i = 1'b0;
         wb_set(0, 3'(i), 64'(i), 16'h0);
         tick();
         idle();
         tick();
      end
      total_cnt++;
      if (count_o !== 4'd0 || alloc_rid_o !== 3'd6)
         $display("FAIL wrap_head got count %0d tail %0d want 0 6", count_o, alloc_rid_o);
      else pass_cnt++;
      cmt_rdy_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         alloc_i = 1'b1;
         #1;
         total_cnt++;
         if (alloc_rid_o !== 3'(exp_r[i]))
            $display("FAIL wrap_rid got %0d want %0d", alloc_rid_o, exp_r[i]);
         else pass_cnt++;
         tick();
      end
      idle();
      for (int p = 0; p < W; p++) wb_set(p, 3'(exp_r[p]), 64'(p), 16'h0);
      tick();
      idle();
      for (int cyc = 0; cyc < 20 && count_o != 0; cyc++) begin
         cmt_rdy_i = cyc[0];
         #1;
         if (cmt_rdy_i)
            for (int k = 0; k < C; k++)
               if (cmt_v_o[k]) got.push_back(int'(cmt_rid_o[k*R +: R]));
         tick();
      end
      cmt_rdy_i = 1'b0;
      total_cnt++;
      if (count_o !== 4'd0 || got.size() != 4)
         $display("FAIL wrap_drain got count %0d commits %0d want 0 4", count_o, got.size());
      else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         total_cnt++;
         if (i >= got.size() || got[i] != exp_r[i])
            $display("FAIL wrap_order idx %0d got %0d want %0d", i,
                     (i < got.size()) ? got[i] : -1, exp_r[i]);
         else pass_cnt++;
      end
   endtask

   initial begin
      idle();
      cmt_rdy_i = 1'b0;
      rst_i = 1'b0;
      test_reset();
      test_fill();
      test_wb_order();
      test_cause();
      test_port_priority();
      test_flush();
      test_wrap();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
